// File: rtl/instruction_fetch_queue.sv
// Sequential instruction fetch with a request/grant + in-order response memory port,
// a DEPTH-entry {pc, instr} queue toward decode, and redirect-driven flush/squash.
module instruction_fetch_queue #(
    parameter int unsigned     XLEN            = 32,
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = '0,
    parameter int unsigned     INSTR_BYTES     = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            write_pc_i,
    input  logic [XLEN-1:0] pc_i,
    output logic            mem_req_o,
    output logic [XLEN-1:0] mem_addr_o,
    input  logic            mem_gnt_i,
    input  logic            mem_rvalid_i,
    input  logic [XLEN-1:0] mem_rdata_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUTSTANDING) + 1;
    localparam int unsigned SUM_W = ((CNT_W > OUT_W) ? CNT_W : OUT_W) + 1;

    localparam logic [XLEN-1:0]  PC_STEP    = XLEN'(INSTR_BYTES);
    localparam logic [OUT_W-1:0] OUT_MAX    = OUT_W'(MAX_OUTSTANDING);
    localparam logic [OUT_W-1:0] OUT_ONE    = OUT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [SUM_W-1:0] CREDIT_MAX = SUM_W'(DEPTH);

    function automatic logic [XLEN-1:0] pc_advance(input logic [XLEN-1:0] pc);
        return pc + PC_STEP;
    endfunction

    logic [XLEN-1:0]  fetch_pc, fetch_pc_nxt;
    logic [XLEN-1:0]  resp_pc, resp_pc_nxt;
    logic [OUT_W-1:0] outstanding, outstanding_nxt;
    logic [OUT_W-1:0] discard, discard_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [SUM_W-1:0] credit_used;

    logic [XLEN-1:0]  pc_q    [DEPTH];
    logic [XLEN-1:0]  instr_q [DEPTH];

    logic req, grant, rsp_accept, push, pop, head_valid;

    // Handshake decode: credit covers both queued entries and in-flight requests
    always_comb begin
        credit_used = SUM_W'(count) + SUM_W'(outstanding);
        head_valid  = (count != '0);
        req         = !write_pc_i && (outstanding < OUT_MAX) && (credit_used < CREDIT_MAX);
        grant       = req && mem_gnt_i;
        rsp_accept  = mem_rvalid_i && (outstanding != '0);
        push        = rsp_accept && (discard == '0) && !write_pc_i;
        pop         = head_valid && ready_i && !write_pc_i;
    end

    always_comb begin
        outstanding_nxt = outstanding;
        case ({grant, rsp_accept})
            2'b10:   outstanding_nxt = outstanding + OUT_ONE;
            2'b01:   outstanding_nxt = outstanding - OUT_ONE;
            default: outstanding_nxt = outstanding;
        endcase

        // A redirect squashes every response still owed after this cycle
        discard_nxt = discard;
        if (write_pc_i) begin
            discard_nxt = outstanding - OUT_W'(rsp_accept);
        end else if (rsp_accept && (discard != '0)) begin
            discard_nxt = discard - OUT_ONE;
        end

        fetch_pc_nxt = fetch_pc;
        resp_pc_nxt  = resp_pc;
        if (write_pc_i) begin
            fetch_pc_nxt = pc_i;
            resp_pc_nxt  = pc_i;
        end else begin
            if (grant) fetch_pc_nxt = pc_advance(fetch_pc);
            if (push)  resp_pc_nxt  = pc_advance(resp_pc);
        end

        count_nxt  = count;
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        if (write_pc_i) begin
            count_nxt  = '0;
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count_nxt = count + CNT_ONE;
                2'b01:   count_nxt = count - CNT_ONE;
                default: count_nxt = count;
            endcase
        end
    end

    // Control state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            fetch_pc    <= fetch_pc_nxt;
            resp_pc     <= resp_pc_nxt;
            outstanding <= outstanding_nxt;
            discard     <= discard_nxt;
            count       <= count_nxt;
            wr_ptr      <= wr_ptr_nxt;
            rd_ptr      <= rd_ptr_nxt;
        end
    end

    // Queue storage; contents are only meaningful under count, so no reset
    always_ff @(posedge clk) begin
        if (push) begin
            pc_q[wr_ptr]    <= resp_pc;
            instr_q[wr_ptr] <= mem_rdata_i;
        end
    end

    always_comb begin
        mem_req_o  = !rst && req;
        mem_addr_o = rst ? '0 : fetch_pc;
        valid_o    = !rst && head_valid;
        pc_o       = valid_o ? pc_q[rd_ptr]    : '0;
        instr_o    = valid_o ? instr_q[rd_ptr] : '0;
    end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue with a latency-programmable in-order memory.
module tb_instruction_fetch_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        write_pc_i;
    logic [31:0] pc_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;

    int vecs = 0;
    int errs = 0;
    int cyc  = 0;
    int lat  = 1;
    int max_out = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t        mq[$];
    logic [31:0] pop_pc[$];
    logic [31:0] pop_instr[$];

    instruction_fetch_queue #(
        .XLEN(32), .DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0), .INSTR_BYTES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .write_pc_i(write_pc_i), .pc_i(pc_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .instr_o(instr_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory responder: decides rvalid/rdata for the coming edge
    initial begin
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (!rst && mq.size() > 0 && mq[0].due <= cyc + 1) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                mem_rvalid_i = 1'b0;
                mem_rdata_i  = '0;
            end
        end
    end

    // Grant recorder and decode-side pop monitor
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
            end else if (mem_req_o && mem_gnt_i) begin
                mq.push_back('{addr: mem_addr_o, due: cyc + 1 + lat});
                if (mq.size() > max_out) max_out = mq.size();
            end
            if (!rst && valid_o && ready_i && !write_pc_i) begin
                pop_pc.push_back(pc_o);
                pop_instr.push_back(instr_o);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not reach its end");
        $fatal(1);
    end

    task automatic do_reset();
        rst        = 1'b1;
        write_pc_i = 1'b0;
        pc_i       = '0;
        repeat (2) @(posedge clk);
        pop_pc.delete();
        pop_instr.delete();
        max_out = 0;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [31:0] exp_pc    [6] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        logic [31:0] exp_instr [6] = '{32'h13579BDF, 32'h13579BDB, 32'h13579BD7,
                                       32'h13579BD3, 32'h13579BCF, 32'h13579BCB};
        int n0;
        bit ok;

        write_pc_i = 1'b0;
        pc_i       = '0;
        ready_i    = 1'b0;
        mem_gnt_i  = 1'b0;

        @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'b0, valid_o}, 32'h0);
        check("rst_req",   {31'b0, mem_req_o}, 32'h0);
        check("rst_addr",  mem_addr_o, 32'h0);
        check("rst_pc",    pc_o, 32'h0);
        check("rst_instr", instr_o, 32'h0);

        // Zero-wait memory, decode always ready
        mem_gnt_i = 1'b1;
        lat       = 1;
        ready_i   = 1'b1;
        do_reset();
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        check("t1_pops", 32'(pop_pc.size()), 32'd19);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("t1_pc%0d", i), pop_pc[i], exp_pc[i]);
            check($sformatf("t1_instr%0d", i), pop_instr[i], exp_instr[i]);
        end

        // Decode stalled: queue fills to DEPTH, then fetch stops
        ready_i = 1'b0;
        do_reset();
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("t2_full_valid", {31'b0, valid_o}, 32'h1);
        check("t2_full_pc",    pc_o, 32'h0);
        check("t2_full_instr", instr_o, 32'h13579BDF);
        check("t2_full_req",   {31'b0, mem_req_o}, 32'h0);
        check("t2_full_addr",  mem_addr_o, 32'h10);
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("t2_pc%0d", i), pop_pc[i], exp_pc[i]);
        end
        check("t2_instr4", pop_instr[4], exp_instr[4]);

        // Response two edges after grant: credit-limited to 2 per 3 cycles
        lat = 2;
        do_reset();
        repeat (10) @(negedge clk);
        #1;
        n0 = pop_pc.size();
        repeat (30) @(negedge clk);
        #1;
        check("t3_throughput", 32'(pop_pc.size() - n0), 32'd20);
        check("t3_max_out",    32'(max_out), 32'd2);
        check("t3_pc1",        pop_pc[1], 32'h4);
        check("t3_instr1",     pop_instr[1], 32'h13579BDB);

        // Redirect with 0,4 queued and 8,12 in flight
        lat     = 4;
        ready_i = 1'b0;
        do_reset();
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (mq.size() == 2 && mq[0].addr == 32'h8 && mq[1].addr == 32'hC) begin
                ok = 1'b1;
                break;
            end
        end
        check("t4_setup", {31'b0, ok}, 32'h1);
        @(posedge clk);
        #1;
        write_pc_i = 1'b1;
        pc_i       = 32'h100;
        @(negedge clk);
        check("t4_pre_valid", {31'b0, valid_o}, 32'h1);
        check("t4_pre_pc",    pc_o, 32'h0);
        check("t4_pre_req",   {31'b0, mem_req_o}, 32'h0);
        @(posedge clk);
        #1;
        write_pc_i = 1'b0;
        ready_i    = 1'b1;
        @(negedge clk);
        check("t4_flush_valid", {31'b0, valid_o}, 32'h0);
        check("t4_flush_addr",  mem_addr_o, 32'h100);
        check("t4_flush_req",   {31'b0, mem_req_o}, 32'h0);
        repeat (20) @(posedge clk);
        @(negedge clk);
        #1;
        check("t4_pc0",    pop_pc[0], 32'h100);
        check("t4_instr0", pop_instr[0], 32'h13579ADF);
        check("t4_pc1",    pop_pc[1], 32'h104);
        check("t4_instr1", pop_instr[1], 32'h13579ADB);

        // Redirect coinciding with a response, then a second redirect right after
        lat = 1;
        do_reset();
        repeat (10) @(posedge clk);
        #1;
        write_pc_i = 1'b1;
        pc_i       = 32'h200;
        pop_pc.delete();
        pop_instr.delete();
        @(posedge clk);
        #1;
        pc_i = 32'h300;
        @(negedge clk);
        check("t5_flush_valid", {31'b0, valid_o}, 32'h0);
        @(posedge clk);
        #1;
        write_pc_i = 1'b0;
        @(negedge clk);
        check("t5_valid", {31'b0, valid_o}, 32'h0);
        check("t5_addr",  mem_addr_o, 32'h300);
        check("t5_req",   {31'b0, mem_req_o}, 32'h1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        #1;
        check("t5_pc0",    pop_pc[0], 32'h300);
        check("t5_instr0", pop_instr[0], 32'h135798DF);
        check("t5_pc1",    pop_pc[1], 32'h304);
        check("t5_instr1", pop_instr[1], 32'h135798DB);

        // Asynchronous reset with a full queue
        ready_i = 1'b0;
        do_reset();
        repeat (8) @(posedge clk);
        #3;
        check("t6_pre_valid", {31'b0, valid_o}, 32'h1);
        check("t6_pre_addr",  mem_addr_o, 32'h10);
        rst = 1'b1;
        #1;
        check("t6_valid", {31'b0, valid_o}, 32'h0);
        check("t6_pc",    pc_o, 32'h0);
        check("t6_instr", instr_o, 32'h0);
        check("t6_req",   {31'b0, mem_req_o}, 32'h0);
        check("t6_addr",  mem_addr_o, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("t6_post_addr",  mem_addr_o, 32'h0);
        check("t6_post_req",   {31'b0, mem_req_o}, 32'h1);
        check("t6_post_valid", {31'b0, valid_o}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
